window_scan_ctrl: RTL

Sequencer for the three-horizontal Haar classifier. On `start` it sweeps a detection window over the 160x120 integral image in raster order. For each window position it computes the eight corner addresses and fires one classification over the `detect_en`/`detect_done` handshake. It then accumulates per-frame hit statistics. It sits between the frame-ready logic of the integral-image buffer and the classifier.

---
 rtl/fd_pkg.sv | 19 +
 rtl/haar3x1_addr_gen.sv | 56 +++++
 rtl/window_scan_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/fd_pkg.sv
// rtl/fd_pkg.sv - shared face-detect constants, address type and scan state encoding
package fd_pkg;

  localparam int II_WIDTH  = 160;
  localparam int II_HEIGHT = 120;
  localparam int ADDR_W    = 15;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_SETUP   = 6'b000010,
    ST_FIRE    = 6'b000100,
    ST_WAIT    = 6'b001000,
    ST_ADVANCE = 6'b010000,
    ST_DONE    = 6'b100000
  } scan_state_t;

endpackage

// File: rtl/haar3x1_addr_gen.sv
// rtl/haar3x1_addr_gen.sv - registered corner addresses for a three-stripe horizontal Haar window
module haar3x1_addr_gen #(
  parameter int IMG_W = fd_pkg::II_WIDTH,
  parameter int SEG_W = 8,
  parameter int WIN_H = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  fd_pkg::addr_t row_base,
  input  logic [7:0]    x,
  output fd_pkg::addr_t address_0,
  output fd_pkg::addr_t address_1,
  output fd_pkg::addr_t address_2,
  output fd_pkg::addr_t address_3,
  output fd_pkg::addr_t address_4,
  output fd_pkg::addr_t address_5,
  output fd_pkg::addr_t address_6,
  output fd_pkg::addr_t address_7
);
  import fd_pkg::*;

  localparam addr_t OFF_S  = addr_t'(SEG_W);
  localparam addr_t OFF_2S = addr_t'(2 * SEG_W);
  localparam addr_t OFF_3S = addr_t'(3 * SEG_W);
  localparam addr_t OFF_H  = addr_t'(WIN_H * IMG_W);

  addr_t top_left;
  addr_t bot_left;

  assign top_left = row_base + addr_t'(x);
  assign bot_left = top_left + OFF_H;

  always_ff @(posedge clk) begin
    if (rst) begin
      address_0 <= '0;
      address_1 <= '0;
      address_2 <= '0;
      address_3 <= '0;
      address_4 <= '0;
      address_5 <= '0;
      address_6 <= '0;
      address_7 <= '0;
    end else if (load) begin
      address_3 <= top_left;
      address_1 <= top_left + OFF_S;
      address_5 <= top_left + OFF_2S;
      address_7 <= top_left + OFF_3S;
      address_2 <= bot_left;
      address_0 <= bot_left + OFF_S;
      address_4 <= bot_left + OFF_2S;
      address_6 <= bot_left + OFF_3S;
    end
  end

endmodule

// File: rtl/window_scan_ctrl.sv
// rtl/window_scan_ctrl.sv - raster window sweep, classifier handshake and per-frame hit statistics
module window_scan_ctrl #(
  parameter int II_WIDTH  = fd_pkg::II_WIDTH,
  parameter int II_HEIGHT = fd_pkg::II_HEIGHT,
  parameter int SEG_W     = 8,
  parameter int WIN_H     = 8,
  parameter int STEP_X    = 4,
  parameter int STEP_Y    = 4,
  parameter int TIMEOUT   = 63
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output fd_pkg::addr_t address_0,
  output fd_pkg::addr_t address_1,
  output fd_pkg::addr_t address_2,
  output fd_pkg::addr_t address_3,
  output fd_pkg::addr_t address_4,
  output fd_pkg::addr_t address_5,
  output fd_pkg::addr_t address_6,
  output fd_pkg::addr_t address_7,
  output logic          detect_en,
  input  logic          detect_done,
  input  logic          detected_flag,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   hit_count,
  output logic          first_hit_valid,
  output logic [7:0]    first_hit_x,
  output logic [6:0]    first_hit_y,
  output logic          timeout_err
);
  import fd_pkg::*;

  localparam int    X_LAST   = ((II_WIDTH - 1 - 3 * SEG_W) / STEP_X) * STEP_X;
  localparam int    Y_LAST   = ((II_HEIGHT - 1 - WIN_H) / STEP_Y) * STEP_Y;
  localparam int    TCNT_W   = $clog2(TIMEOUT + 1);
  localparam addr_t ROW_STEP = addr_t'(STEP_Y * II_WIDTH);

  scan_state_t       state;
  scan_state_t       state_next;
  logic [7:0]        x;
  logic [6:0]        y;
  addr_t             row_base;
  logic [TCNT_W-1:0] tcnt;
  logic [15:0]       hit_cnt;
  logic              timed_out;
  logic              x_wrap;
  logic              y_wrap;

  // tcnt counts completed WAIT cycles, so this marks the TIMEOUT-th one
  assign timed_out = (tcnt == TCNT_W'(TIMEOUT - 1));
  assign x_wrap    = (x == 8'(X_LAST));
  assign y_wrap    = (y == 7'(Y_LAST));
  assign hit_count = hit_cnt;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    detect_en  = 1'b0;
    busy       = 1'b1;
    frame_done = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_next = ST_SETUP;
      end
      ST_SETUP: state_next = ST_FIRE;
      ST_FIRE: begin
        detect_en  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (detect_done || timed_out) state_next = ST_ADVANCE;
      end
      ST_ADVANCE: state_next = (x_wrap && y_wrap) ? ST_DONE : ST_SETUP;
      ST_DONE: begin
        busy       = 1'b0;
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x               <= '0;
      y               <= '0;
      row_base        <= '0;
      tcnt            <= '0;
      hit_cnt         <= '0;
      first_hit_valid <= 1'b0;
      first_hit_x     <= '0;
      first_hit_y     <= '0;
      timeout_err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            x               <= '0;
            y               <= '0;
            row_base        <= '0;
            hit_cnt         <= '0;
            first_hit_valid <= 1'b0;
            timeout_err     <= 1'b0;
          end
        end
        ST_FIRE: tcnt <= '0;
        ST_WAIT: begin
          tcnt <= tcnt + 1'b1;
          // a done landing on the final counted cycle still wins over the timeout
          if (detect_done) begin
            if (detected_flag) begin
              if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
              if (!first_hit_valid) begin
                first_hit_valid <= 1'b1;
                first_hit_x     <= x;
                first_hit_y     <= y;
              end
            end
          end else if (timed_out) begin
            timeout_err <= 1'b1;
          end
        end
        ST_ADVANCE: begin
          if (x_wrap) begin
            x <= '0;
            if (!y_wrap) begin
              y        <= y + 7'(STEP_Y);
              row_base <= row_base + ROW_STEP;
            end
          end else begin
            x <= x + 8'(STEP_X);
          end
        end
        default: ;
      endcase
    end
  end

  haar3x1_addr_gen #(
    .IMG_W(II_WIDTH),
    .SEG_W(SEG_W),
    .WIN_H(WIN_H)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (state == ST_SETUP),
    .row_base (row_base),
    .x        (x),
    .address_0(address_0),
    .address_1(address_1),
    .address_2(address_2),
    .address_3(address_3),
    .address_4(address_4),
    .address_5(address_5),
    .address_6(address_6),
    .address_7(address_7)
  );

endmodule
